// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read-side adapter: credit-gated read enable, read-latency absorption and a valid/ready skid buffer.
// Optional line marker (beat counter driving m_last) is compiled in with `define FIFO_ADAPTER_LAST_EN.
module fifo_rd_stream_adapter #(
    parameter int unsigned c_DATA_WIDTH = 32,
    parameter int unsigned c_RD_LATENCY = 1,
    parameter int unsigned c_LINE_LEN   = 1280
) (
    input  logic                    rd_clk,
    input  logic                    rd_rst,
    input  logic [c_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                    fifo_rd_empty,
    output logic                    fifo_rd_en,
    output logic [c_DATA_WIDTH-1:0] m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic [2:0]              occupancy
);

    localparam int unsigned c_DEPTH  = c_RD_LATENCY + 2;
    localparam int unsigned c_CNT_W  = 3;
    localparam int unsigned c_PTR_W  = 2;
    localparam int unsigned c_BEAT_W = 12;

    logic [c_RD_LATENCY-1:0] r_inflight_sr;
    logic [c_CNT_W-1:0]      r_count;
    logic [c_PTR_W-1:0]      r_wptr;
    logic [c_PTR_W-1:0]      r_rptr;
    logic [c_DATA_WIDTH-1:0] r_buf [c_DEPTH];

    logic               w_arrive;
    logic               w_pop;
    logic               w_rd_en;
    logic [c_CNT_W-1:0] w_inflight;
    logic [c_CNT_W-1:0] w_occupancy;

    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(c_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    // Reads in flight are credits already spent against the buffer.
    always_comb begin
        w_inflight = '0;
        for (int unsigned i = 0; i < c_RD_LATENCY; i++) begin
            w_inflight = w_inflight + c_CNT_W'(r_inflight_sr[i]);
        end
    end

    assign w_occupancy = r_count + w_inflight;
    assign w_arrive    = r_inflight_sr[c_RD_LATENCY-1];
    assign w_rd_en     = !rd_rst && !fifo_rd_empty && (w_occupancy < c_CNT_W'(c_DEPTH));
    assign w_pop       = m_valid && m_ready;

    assign fifo_rd_en  = w_rd_en;
    assign occupancy   = w_occupancy;
    assign m_valid     = (r_count != '0);
    assign m_data      = r_buf[r_rptr];

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_inflight_sr <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            r_inflight_sr <= c_RD_LATENCY'({r_inflight_sr, w_rd_en});
            if (w_arrive) begin
                r_wptr <= f_ptr_inc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= f_ptr_inc(r_rptr);
            end
            case ({w_arrive, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is not reset; m_data is only meaningful while m_valid is high.
    always_ff @(posedge rd_clk) begin
        if (!rd_rst && w_arrive) begin
            r_buf[r_wptr] <= fifo_rd_data;
        end
    end

`ifdef FIFO_ADAPTER_LAST_EN
    logic [c_BEAT_W-1:0] r_beat_cnt;

    assign m_last = m_valid && (r_beat_cnt == c_BEAT_W'(c_LINE_LEN - 1));

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= m_last ? '0 : r_beat_cnt + c_BEAT_W'(1);
        end
    end
`else
    logic [c_BEAT_W-1:0] w_unused_line_len;

    assign w_unused_line_len = c_BEAT_W'(c_LINE_LEN);
    assign m_last            = 1'b0;
`endif

endmodule

// File: doc/fifo_rd_stream_adapter.md
# fifo_rd_stream_adapter

Read-side stage that sits directly downstream of the parameterized FIFO in the HDMI datapath. It drives the FIFO's read enable against `rd_empty`, absorbs the FIFO's fixed read latency (1 cycle without the output register, 2 with it), and presents the data as a valid/ready stream to the pixel pipeline. A small credit-controlled skid buffer guarantees no word is lost under backpressure and sustains one word per cycle when the consumer is always ready.

## Interface
Parameters:
- `c_DATA_WIDTH`, 32: width of FIFO read data and stream data.
- `c_RD_LATENCY`, 1: FIFO read latency in cycles from `fifo_rd_en` to valid `fifo_rd_data`. Legal values are 1 and 2; 2 matches the FIFO built with its output register.
- `c_LINE_LEN`, 1280: beats per video line, used for `m_last`. Legal range is 2 to 4096.

Ports (clock and reset first):
- `rd_clk`, in, 1: single clock, shared with the FIFO read side.
- `rd_rst`, in, 1: reset, synchronous, active-high.
- `fifo_rd_data`, in, `c_DATA_WIDTH`: FIFO read data.
- `fifo_rd_empty`, in, 1: FIFO empty flag.
- `fifo_rd_en`, out, 1: FIFO read enable.
- `m_data`, out, `c_DATA_WIDTH`: stream data.
- `m_valid`, out, 1: stream valid.
- `m_ready`, in, 1: stream ready.
- `m_last`, out, 1: last beat of a line.
- `occupancy`, out, 3: words held in the buffer plus reads in flight.

## Operation
- Buffer depth `D = c_RD_LATENCY + 2`. It is circular, with a 2-bit write pointer and read pointer and a 3-bit `count`.
- In-flight tracker: a `c_RD_LATENCY`-bit shift register `inflight_sr`. Bit 0 is loaded with `fifo_rd_en` each cycle. A 1 leaving the top bit marks `fifo_rd_data` as valid in that cycle; that word is written to `buf[wptr]` and `wptr` increments mod D.
- `inflight` is the popcount of `inflight_sr`, and `occupancy = count + inflight`.
- `fifo_rd_en = !rd_rst && !fifo_rd_empty && (occupancy < D)`. It is a function of registered state and `fifo_rd_empty` only, with no path from `m_ready`.
- `m_valid = (count != 0)` and `m_data = buf[rptr]`.
- A pop occurs when `m_valid && m_ready`; `rptr` then increments mod D.
- Count update: `count += arrive - pop`. Simultaneous arrive and pop leaves `count` unchanged.
- Overflow is impossible by construction because the credit check bounds `occupancy` at D.
- Line counter `beat_cnt` (12-bit):
  - It increments on each pop.
  - `m_last = m_valid && (beat_cnt == c_LINE_LEN-1)`.
  - On a pop while `m_last` is high, `beat_cnt` wraps to 0.
- Reset:
  - `inflight_sr`, `count`, both pointers and `beat_cnt` clear to 0, so every output is 0.
  - `fifo_rd_en` is forced to 0 while `rd_rst` is high.
  - Words in flight when reset asserts are discarded. `rd_rst` is the same signal that resets the FIFO read side.
- Buffer contents are not reset; `m_data` is don't-care while `m_valid` is 0.

## Timing
- Latency from the first `fifo_rd_en` to `m_valid` is `c_RD_LATENCY + 1` cycles, because the buffer write is registered.
- Throughput: with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` stays high every cycle and `m_valid` stays high every cycle after fill. In steady state `occupancy` is `c_RD_LATENCY + 1`, which is less than D.
- Backpressure: when `m_ready` drops, at most D words accumulate, and `fifo_rd_en` deasserts in the cycle `occupancy` reaches D. It re-asserts in the cycle after the first pop.
- `fifo_rd_empty` rising stops reads on the same cycle. Words already in flight still arrive.
- Stream rule: once `m_valid` is high, `m_data` and `m_last` hold stable until a pop.

## Configuration
- Macro: `FIFO_ADAPTER_LAST_EN`.
- Defined: `beat_cnt` and the `m_last` logic are compiled in as described above.
- Undefined: `beat_cnt` is removed, `m_last` is tied to 0, and `c_LINE_LEN` is ignored. Everything else is identical.

## Test plan
- Reset and idle: hold `rd_rst` for 3 cycles with FIFO model non-empty. Required: `fifo_rd_en`, `m_valid`, `m_last` and `occupancy` are all 0. After release, `fifo_rd_en` goes to 1 on the first cycle.
- Streaming, `c_RD_LATENCY` = 1 and 2: preload 64 words 0..63 with `m_ready` = 1. Required:
  - 64 consecutive beats with no `m_valid` gap after the first.
  - Data in order 0..63.
  - First `m_valid` at cycle L+1.
- Backpressure: `m_ready` = 0 for 10 cycles mid-stream. Required:
  - `occupancy` peaks at D (3 or 4).
  - `fifo_rd_en` stays 0 while full.
  - No loss or duplication.
  - `m_data` is stable while stalled.
- Empty and in-flight boundary: FIFO holds 1 word, then a pulse of 1 is written later. Required: exactly 2 beats, and `fifo_rd_en` is never asserted while `fifo_rd_empty` = 1.
- Line marker with `FIFO_ADAPTER_LAST_EN`, `c_LINE_LEN` = 4, random `m_ready`: send 12 words. Required: `m_last` is high on beats 3, 7 and 11 only.
- Reset mid-stream: assert `rd_rst` with 2 words in flight and 2 buffered. Required: all outputs are 0 the next cycle, and the stream restarts with no stale words.
